// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, EX redirect and the decode-facing output.
// master = fetch unit side, slave = memory/pipeline environment side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch, prefetch FIFO, redirect drain.
// Optional FETCH_BYPASS_EN: a response into an empty FIFO is presented to decode the same cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]   fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] count, live_cnt, drop_cnt, drop_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic          empty, full, rsp_run, rsp_drain, req_fire, push, pop, byp, redir;

  assign redir     = bus.redirect_valid;
  assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  // A response with nothing outstanding is ignored rather than pushed.
  assign rsp_run   = bus.imem_rsp_valid && (state == RUN) && (live_cnt != '0);
  assign rsp_drain = bus.imem_rsp_valid && (state == DRAIN);

  // FIFO slots plus live requests form the credit pool, so a push never finds the FIFO full.
  assign bus.imem_req_valid = !rst && !redir && ((count + live_cnt) < CW'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign byp = empty && rsp_run && !redir;
`else
  assign byp = 1'b0;
`endif

  assign pop           = !empty && bus.out_ready && !redir;
  assign push          = rsp_run && !redir && !(byp && bus.out_ready);
  assign bus.out_valid = !rst && (!empty || byp);
  assign bus.out_pc    = !empty ? pc_mem[rd_ptr]    : (byp ? rsp_pc            : '0);
  assign bus.out_instr = !empty ? instr_mem[rd_ptr] : (byp ? bus.imem_rsp_data : '0);

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (redir) begin
      // Everything still in flight becomes stale, minus whatever lands this cycle.
      drop_nxt  = drop_cnt + live_cnt - CW'(rsp_run) - CW'(rsp_drain);
      state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
    end else if (rsp_drain) begin
      drop_nxt = drop_cnt - CW'(1);
      if (drop_cnt == CW'(1)) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      drop_cnt <= '0;
      live_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (redir) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        live_cnt <= '0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_run)  rsp_pc   <= rsp_pc + 32'd4;
        live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_run);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_orphan:   assert property (@(posedge clk) disable iff (rst)
                   !(bus.imem_rsp_valid && ((live_cnt + drop_cnt) == '0)));
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID register in the 4-stage core.
- Generates sequential PCs and issues requests on a valid/ready instruction-memory port.
- Accepts in-order, variable-latency responses into a small prefetch FIFO and presents {pc, instr} to decode with a valid/ready handshake.
- Handles EX-stage branch redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid, in request order, no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch taken in EX; flush and refetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated 0).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts (driven by IF/ID write enable).
- out_pc  out  32  PC of the presented instruction.
- out_instr  out  32  presented instruction.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All state is clocked on posedge clk.
- Reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, live_cnt=0, drop_cnt=0, state=RUN. imem_req_valid=0 and out_valid=0 while rst is high. out_pc and out_instr are 0 while the FIFO is empty.
- Request issue: imem_req_valid=1 when (fifo_count + live_cnt) < FIFO_DEPTH and redirect_valid=0; imem_req_addr=fetch_pc.
- Request handshake: on imem_req_valid && imem_req_ready, fetch_pc += 4 (wraps modulo 2^32) and live_cnt++. imem_req_addr must hold stable while valid and not ready, unless a redirect occurs.
- First request is issued the first cycle after reset deasserts.
- Response, state RUN: push {rsp_pc, imem_rsp_data} into the FIFO; rsp_pc += 4; live_cnt--.
- Response, state DRAIN: discard the response; drop_cnt--. When drop_cnt reaches 0, return to RUN.
- Credit rule: the FIFO can never overflow. A response arriving with the FIFO full is impossible by construction; assertion fires if it occurs.
- Output: out_valid = FIFO not empty; out_pc and out_instr come from the FIFO head (registered). Pop on out_valid && out_ready. Minimum latency: response in cycle N, out_valid in cycle N+1.
- Simultaneous push and pop with FIFO full: allowed, count unchanged.
- Redirect (redirect_valid=1), in the same cycle:
  - FIFO flushed.
  - Any response arriving is discarded.
  - Any pop is ignored.
  - imem_req_valid is forced to 0.
- Redirect, next state:
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = live_cnt + drop_cnt − (arriving RUN response ? 1 : 0) − (arriving DRAIN response ? 1 : 0).
  - live_cnt = 0.
  - state = DRAIN if drop_cnt > 0, else RUN.
- Back-to-back redirects accumulate into drop_cnt.
- In DRAIN, new requests may issue. Because responses are in order, the first drop_cnt responses are stale.
- Counters are $clog2(FIFO_DEPTH)+2 bits wide.
- imem_rsp_valid with live_cnt+drop_cnt == 0: ignored; assertion fires.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight memory responses are the memory's responsibility (it is reset by the same rst).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined: if the FIFO is empty, state=RUN, imem_rsp_valid=1 and no redirect, the response drives out_valid/out_pc/out_instr combinationally in the same cycle. If out_ready=1 the response is consumed without a FIFO write; otherwise it is pushed as normal. Latency becomes 0 cycles response-to-output.
- When undefined: outputs are purely registered from the FIFO head, with latency 1.

Test Plan:
- Streaming: reset, memory with ready=1 and fixed 1-cycle latency, out_ready=1 → requests at 0x0,0x4,0x8,…; out_pc/out_instr sequence matches, one per cycle in steady state, first out_valid 3 cycles after reset release.
- Backpressure: out_ready=0 with FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; raise out_ready → instructions 0x0..0xC delivered in order, fetch resumes at 0x10.
- Redirect with 3 live requests, redirect_pc=0x100 → next 3 responses dropped; first out_pc=0x100 with that response's data; no stale instruction reaches out_valid.
- Redirect coinciding with a response and a pop, then a second redirect to 0x200 two cycles later → drop_cnt accounting correct; output resumes at 0x200 only.
- Request stall: imem_req_ready=0 for 5 cycles → imem_req_addr holds, fetch_pc unchanged; redirect during the stall changes imem_req_addr to the new PC.
- Reset asserted mid-stream with FIFO half full → out_valid=0 immediately; fetch restarts at RESET_PC. With FETCH_BYPASS_EN: empty FIFO plus response → out_valid the same cycle.
